// File: rtl/apb_mailbox_pkg.sv
// Shared definitions for apb_mailbox: register offsets, APB FSM states, STATUS layout.
// The IRQ_CFG offset is defined here in every build; only the top decides whether it decodes.
package apb_mailbox_pkg;

  localparam int unsigned DATA_OFF   = 32'h0;
  localparam int unsigned STATUS_OFF = 32'h4;
  localparam int unsigned CTRL_OFF   = 32'h8;
  localparam int unsigned IRQ_OFF    = 32'hC;

  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_CLR_OVF  = 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  typedef struct packed {
    logic [15:0] rsvd;
    logic [7:0]  rx_cnt;
    logic [3:0]  tx_cnt;
    logic        rx_empty;
    logic        tx_full;
    logic        rx_ovf;
    logic        tx_ovf;
  } status_t;

endpackage

// File: rtl/apb_mailbox_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags. Data appears one cycle after push (no bypass).
// A pop on a full FIFO frees a slot for a same-cycle push; flush beats push and pop.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_mailbox.sv
// APB mailbox: TX/RX byte FIFOs; response registered entering ACCESS, side effects on the edge leaving it.
// Streams use valid/ready from registered FIFO flags; APB_MAILBOX_IRQ_EN adds irq and the IRQ_CFG register.
module apb_mailbox
  import apb_mailbox_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
`ifdef APB_MAILBOX_IRQ_EN
  ,
  output logic              irq
`endif
);

  apb_state_t state;
  apb_state_t state_nxt;

  logic [ADDR_W-1:0]     off;
  logic                  enter_acc;
  logic                  acc_end;
  logic [31:0]           rd_val;
  logic                  dec_err, dec_push, dec_pop, dec_ctrl, dec_irqw, dec_txovf, dec_rxovf;
  logic                  acc_push, acc_pop, acc_ctrl, acc_irqw, acc_txovf, acc_rxovf;
  logic [31:0]           acc_wdata;
  logic                  tx_ovf, rx_ovf, rdy_en;
  status_t               status;

  logic [DATA_W-1:0]     tx_rdata, rx_rdata;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [$clog2(DEPTH):0] tx_cnt, rx_cnt;
  logic                  rx_pop;
  logic                  unused_ok;

`ifdef APB_MAILBOX_IRQ_EN
  logic       irq_tx_en, irq_rx_en;
  logic [3:0] irq_thresh;
`endif

  assign off       = {paddr[ADDR_W-1:2], 2'b00};
  assign enter_acc = (state == SETUP) && psel && penable;
  assign acc_end   = (state == ACCESS);
  assign pready    = 1'b1;
  assign unused_ok = ^{paddr[1:0], acc_wdata};

  always_comb begin
    status          = '0;
    status.rx_cnt   = 8'(rx_cnt);
    status.tx_cnt   = 4'(tx_cnt);
    status.rx_empty = rx_empty;
    status.tx_full  = tx_full;
    status.rx_ovf   = rx_ovf;
    status.tx_ovf   = tx_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // penable from IDLE is not a transfer: IDLE simply holds.
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    if (psel && !penable) state_nxt = SETUP;
      SETUP:   if (psel && penable) state_nxt = ACCESS;
               else if (psel && !penable) state_nxt = SETUP;
      ACCESS:  if (psel && !penable) state_nxt = SETUP;
      default: state_nxt = IDLE;
    endcase

    rd_val    = '0;
    dec_err   = 1'b0;
    dec_push  = 1'b0;
    dec_pop   = 1'b0;
    dec_ctrl  = 1'b0;
    dec_irqw  = 1'b0;
    dec_txovf = 1'b0;
    dec_rxovf = 1'b0;
    case (off)
      ADDR_W'(DATA_OFF): begin
        if (pwrite) begin
          if (tx_full) begin
            dec_err   = 1'b1;
            dec_txovf = 1'b1;
          end else begin
            dec_push  = 1'b1;
          end
        end else if (rx_empty) begin
          dec_err   = 1'b1;
          dec_rxovf = 1'b1;
        end else begin
          dec_pop = 1'b1;
          rd_val  = 32'(rx_rdata);
        end
      end
      ADDR_W'(STATUS_OFF): begin
        if (pwrite) dec_err = 1'b1;
        else        rd_val  = status;
      end
      ADDR_W'(CTRL_OFF): dec_ctrl = pwrite;
      ADDR_W'(IRQ_OFF): begin
`ifdef APB_MAILBOX_IRQ_EN
        if (pwrite) dec_irqw = 1'b1;
        else        rd_val   = {20'b0, irq_thresh, 6'b0, irq_rx_en, irq_tx_en};
`else
        dec_err = 1'b1;
`endif
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Decisions are frozen at ACCESS entry so stream traffic during ACCESS cannot change the outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      prdata    <= '0;
      pslverr   <= 1'b0;
      acc_push  <= 1'b0;
      acc_pop   <= 1'b0;
      acc_ctrl  <= 1'b0;
      acc_irqw  <= 1'b0;
      acc_txovf <= 1'b0;
      acc_rxovf <= 1'b0;
      acc_wdata <= '0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (enter_acc) begin
        prdata    <= rd_val;
        pslverr   <= dec_err;
        acc_push  <= dec_push;
        acc_pop   <= dec_pop;
        acc_ctrl  <= dec_ctrl;
        acc_irqw  <= dec_irqw;
        acc_txovf <= dec_txovf;
        acc_rxovf <= dec_rxovf;
        acc_wdata <= pwdata;
      end else begin
        prdata  <= '0;
        pslverr <= 1'b0;
      end
      if (acc_end && acc_ctrl && acc_wdata[CTRL_CLR_OVF]) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
      end else begin
        if (acc_end && acc_txovf) tx_ovf <= 1'b1;
        if (acc_end && acc_rxovf) rx_ovf <= 1'b1;
      end
    end
  end

`ifdef APB_MAILBOX_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_tx_en  <= 1'b0;
      irq_rx_en  <= 1'b0;
      irq_thresh <= '0;
      irq        <= 1'b0;
    end else begin
      if (acc_end && acc_irqw) begin
        irq_tx_en  <= acc_wdata[0];
        irq_rx_en  <= acc_wdata[1];
        irq_thresh <= acc_wdata[11:8];
      end
      irq <= (irq_tx_en && (tx_cnt == '0)) ||
             (irq_rx_en && (32'(rx_cnt) > 32'(irq_thresh))) || rx_ovf || tx_ovf;
    end
  end
`endif

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (acc_end && acc_push),
    .pop   (tx_ready),
    .flush (acc_end && acc_ctrl && acc_wdata[CTRL_TX_FLUSH]),
    .wdata (acc_wdata[DATA_W-1:0]),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  // A full RX still takes rx_data on the edge an APB pop frees a slot, so the count holds at DEPTH.
  assign rx_pop = acc_end && acc_pop;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid && (rx_ready || rx_pop)),
    .pop   (rx_pop),
    .flush (acc_end && acc_ctrl && acc_wdata[CTRL_RX_FLUSH]),
    .wdata (rx_data),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_valid ? tx_rdata : '0;
  assign rx_ready = rdy_en & ~rx_full;

endmodule

// File: tb/tb_apb_mailbox.sv
// Bench for apb_mailbox: directed steps then random traffic checked against a queue-based mailbox model.
module tb_apb_mailbox;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef APB_MAILBOX_IRQ_EN
  logic        irq;
  logic [11:0] m_cfg;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_txovf, m_rxovf;

  apb_mailbox #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef APB_MAILBOX_IRQ_EN
    , .irq(irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(rx_q.size()), 4'(tx_q.size()), rx_q.size() == 0,
            tx_q.size() == DEPTH, m_rxovf, m_txovf};
  endfunction

  // One transfer: setup, access, then the mailbox's registered ACCESS cycle where the response is sampled.
  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] wd, input logic side,
                     input logic [7:0] sdat, output logic [31:0] rd, output logic er);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = $urandom;
    rx_valid = side; rx_data = sdat;
    rd = prdata; er = pslverr;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_apb(input string tag, input logic wr, input logic [3:0] a, input logic [31:0] wd,
                        input logic side, input logic [7:0] sdat);
    logic [31:0] exp_rd, rd;
    logic        exp_err, er, popped;
    exp_rd = '0; exp_err = 1'b0; popped = 1'b0;
    case (a[3:2])
      2'd0: begin
        if (wr) begin
          if (tx_q.size() == DEPTH) begin exp_err = 1'b1; m_txovf = 1'b1; end
          else tx_q.push_back(wd[7:0]);
        end else if (rx_q.size() == 0) begin
          exp_err = 1'b1; m_rxovf = 1'b1;
        end else begin
          exp_rd = {24'h0, rx_q[0]}; popped = 1'b1;
        end
      end
      2'd1: begin
        if (wr) exp_err = 1'b1;
        else    exp_rd = exp_status();
      end
      2'd2: ;
      default: begin
`ifdef APB_MAILBOX_IRQ_EN
        if (wr) m_cfg = wd[11:0] & 12'hF03;
        else    exp_rd = {20'h0, m_cfg};
`else
        exp_err = 1'b1;
`endif
      end
    endcase
    apb(wr, a, wd, side, sdat, rd, er);
    if (popped) void'(rx_q.pop_front());
    if (side && rx_q.size() < DEPTH) rx_q.push_back(sdat);
    if (wr && a[3:2] == 2'd2) begin
      if (wd[0]) tx_q.delete();
      if (wd[1]) rx_q.delete();
      if (wd[2]) begin m_txovf = 1'b0; m_rxovf = 1'b0; end
    end
    chk({tag, "_prdata"}, rd, exp_rd);
    chk({tag, "_pslverr"}, {31'h0, er}, {31'h0, exp_err});
  endtask

  task automatic stream(input logic [7:0] b);
    chk("rx_ready", {31'h0, rx_ready}, {31'h0, rx_q.size() < DEPTH});
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
  endtask

  task automatic drain();
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, tx_q.size() > 0});
    chk("tx_data", {24'h0, tx_data}, (tx_q.size() > 0) ? {24'h0, tx_q[0]} : 32'h0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    if (tx_q.size() > 0) void'(tx_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    m_txovf = 1'b0; m_rxovf = 1'b0;
`ifdef APB_MAILBOX_IRQ_EN
    m_cfg = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h1);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    do_apb("rst_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h0);

    // Single push, then drain.
    do_apb("wr_a5", 1'b1, 4'h0, 32'hFFFF_FFA5, 1'b0, 8'h0);
    chk("a5_valid", {31'h0, tx_valid}, 32'h1);
    chk("a5_data", {24'h0, tx_data}, 32'hA5);
    drain();
    chk("a5_drained", {31'h0, tx_valid}, 32'h0);

    // Overfill TX, clear sticky flags, flush TX.
    for (int i = 0; i < DEPTH + 1; i++) do_apb("tx_fill", 1'b1, 4'h0, 32'(i + 1), 1'b0, 8'h0);
    do_apb("tx_full_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h0);
    do_apb("ctrl_clr", 1'b1, 4'h8, 32'h4, 1'b0, 8'h0);
    do_apb("clr_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h0);
    do_apb("ctrl_txflush", 1'b1, 4'h8, 32'h1, 1'b0, 8'h0);
    drain();

    // RX in order, then underflow.
    stream(8'h11);
    stream(8'h22);
    do_apb("rx_rd1", 1'b0, 4'h0, 32'h0, 1'b0, 8'h0);
    do_apb("rx_rd2", 1'b0, 4'h0, 32'h0, 1'b0, 8'h0);
    do_apb("rx_rd3", 1'b0, 4'h0, 32'h0, 1'b0, 8'h0);
    do_apb("rx_ovf_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h0);

    // Full RX: pop and stream push on the same edge.
    for (int i = 0; i < DEPTH; i++) stream(8'($urandom));
    chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
    do_apb("rx_full_rdpush", 1'b0, 4'h0, 32'h0, 1'b1, 8'h5C);
    chk("rx_still_full", {31'h0, rx_ready}, 32'h0);
    do_apb("rx_full_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h0);
    for (int i = 0; i < DEPTH; i++) do_apb("rx_order", 1'b0, 4'h0, 32'h0, 1'b0, 8'h0);

    // Decode corners.
    do_apb("status_wr", 1'b1, 4'h4, 32'hFFFF_FFFF, 1'b0, 8'h0);
    do_apb("ctrl_rd", 1'b0, 4'h8, 32'h0, 1'b0, 8'h0);
    do_apb("off_c_rd", 1'b0, 4'hC, 32'h0, 1'b0, 8'h0);
    do_apb("ctrl_clr2", 1'b1, 4'h8, 32'h4, 1'b0, 8'h0);

    // penable without a setup phase has no effect.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h33;
    repeat (2) @(posedge clk);
    #1;
    chk("orphan_pslverr", {31'h0, pslverr}, 32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("orphan_no_push", {31'h0, tx_valid}, 32'h0);

    // Reset in the middle of a transfer discards everything.
    do_apb("pre_rst_wr", 1'b1, 4'h0, 32'h44, 1'b0, 8'h0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
    tx_q.delete(); rx_q.delete(); m_txovf = 1'b0; m_rxovf = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    do_apb("midrst_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h0);

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: do_apb("r_wr", 1'b1, 4'h0, $urandom, 1'b0, 8'h0);
        1: do_apb("r_rd", 1'b0, 4'h0, 32'h0, $urandom_range(0, 3) == 0, 8'($urandom));
        2: do_apb("r_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h0);
        3: stream(8'($urandom));
        4: drain();
        5: do_apb("r_ctrl", 1'b1, 4'h8, 32'($urandom_range(0, 7)), 1'b0, 8'h0);
        default: do_apb("r_misc", 1'($urandom_range(0, 1)), 4'($urandom_range(1, 3) << 2),
                        $urandom, 1'b0, 8'h0);
      endcase
    end
    do_apb("final_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h0);

`ifdef APB_MAILBOX_IRQ_EN
    do_apb("irq_prep", 1'b1, 4'h8, 32'h7, 1'b0, 8'h0);
    do_apb("irq_cfg_wr", 1'b1, 4'hC, 32'h0202, 1'b0, 8'h0);
    do_apb("irq_cfg_rd", 1'b0, 4'hC, 32'h0, 1'b0, 8'h0);
    stream(8'h01);
    stream(8'h02);
    stream(8'h03);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_rise", {31'h0, irq}, 32'h1);
    do_apb("irq_pop", 1'b0, 4'h0, 32'h0, 1'b0, 8'h0);
    @(posedge clk); #1;
    chk("irq_fall", {31'h0, irq}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
